// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART 8N1 receiver that loads 32-bit words into instruction memory
module uart_prog_loader #(
    parameter int CLK_DIV   = 868,
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] MAX_CNT   = 16'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {F_IDLE, F_CNT_LO, F_DATA, F_DONE, F_ERR} f_state_e;

    // Receiver state
    logic      rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_e rx_state_q, rx_state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_err_q, frame_err_d;

    // Framer state
    f_state_e    f_state_q, f_state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [15:0] hdr_count;
    logic [31:0] next_word;

    assign hdr_count = {count_q[15:8], shift_q};
    assign next_word = {asm_q[23:0], shift_q};

    // Synchroniser flops idle high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Receiver register update
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q   <= RX_IDLE;
            baud_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Receiver next state: mid-bit sampling, LSB first, stop bit decides valid vs error
    always_comb begin
        rx_state_d   = rx_state_q;
        baud_d       = baud_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = RX_START;
                    baud_d     = '0;
                end
            end
            RX_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d     = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                    else                   bit_idx_d  = bit_idx_q + 3'd1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                if (baud_q == BIT_LAST) begin
                    baud_d       = '0;
                    byte_valid_d = rxd_sync_q;
                    frame_err_d  = !rxd_sync_q;
                    rx_state_d   = RX_IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
        endcase
    end

    // Framer register update
    always_ff @(posedge clk) begin
        if (!rst) begin
            f_state_q   <= F_IDLE;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            f_state_q   <= f_state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Framer next state: header parse, word assembly, write strobe, session status
    always_comb begin
        f_state_d   = f_state_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        if (frame_err_q && f_state_q != F_ERR) begin
            f_state_d = F_ERR;
            busy_d    = 1'b0;
            err_d     = 1'b1;
        end else begin
            case (f_state_q)
                F_IDLE, F_DONE: begin
                    if (byte_valid_q) begin
                        count_d[15:8] = shift_q;
                        busy_d        = 1'b1;
                        done_d        = 1'b0;
                        f_state_d     = F_CNT_LO;
                    end
                end
                F_CNT_LO: begin
                    if (byte_valid_q) begin
                        count_d = hdr_count;
                        if (hdr_count == 16'd0) begin
                            f_state_d = F_DONE;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                        end else if (hdr_count > MAX_CNT) begin
                            f_state_d = F_ERR;
                            busy_d    = 1'b0;
                            err_d     = 1'b1;
                        end else begin
                            f_state_d  = F_DATA;
                            word_idx_d = '0;
                            byte_idx_d = '0;
                        end
                    end
                end
                F_DATA: begin
                    // word_idx already advanced, so equality marks the final strobe cycle
                    if (mem_we_q && word_idx_q == count_q) begin
                        f_state_d = F_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else if (byte_valid_q) begin
                        asm_d = next_word;
                        if (byte_idx_q == 2'd3) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {14'd0, word_idx_q, 2'b00};
                            mem_wdata_d = next_word;
                            word_idx_d  = word_idx_q + 16'd1;
                            byte_idx_d  = '0;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial program loader: the writer side of the instruction memory that the CPU datapath reads.
- Receives 8N1 UART bytes from a host, assembles them into 32-bit instruction words, and issues one-cycle write strobes into instruction memory at word addresses 0, 4, 8, ….
- Asserts busy while loading; top level uses it to hold the PC register disabled and the CPU idle.

Parameters:
- CLK_DIV, 868: clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- MAX_WORDS, 1024: largest word count accepted in a header.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- rxd  in  1  UART serial input, idle high; asynchronous to clk
- mem_we  out  1  one-cycle instruction-memory write strobe
- mem_addr  out  32  byte address of the word being written (word_idx*4)
- mem_wdata  out  32  instruction word
- busy  out  1  high while a load session is in progress
- done  out  1  sticky: last session completed successfully
- err  out  1  sticky: framing error or header count > MAX_WORDS

Behaviour:
- Reset (rst=0 at a clk edge):
  - all outputs 0; RX and frame FSMs to IDLE; counters 0.
  - Reset mid-session abandons it; words already written stay in memory.
- rxd sync: 2-flop synchroniser; all logic uses the synchronised value (2-cycle input latency).
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE→RX_START on a synced high→low transition.
  - RX_START: wait CLK_DIV/2 cycles, then sample. Low→RX_DATA. High→RX_IDLE (glitch; no error).
  - RX_DATA: 8 samples spaced CLK_DIV cycles, LSB first.
  - RX_STOP: one sample CLK_DIV later. High→byte_valid pulses for 1 cycle with the byte, then RX_IDLE. Low→frame_err pulse, then RX_IDLE.
- Frame FSM states: F_IDLE, F_CNT_LO, F_DATA, F_DONE, F_ERR.
  - Header is a 16-bit word count, big-endian: high byte first.
  - F_IDLE: on byte_valid, store count[15:8], set busy=1, clear done, go F_CNT_LO.
  - F_CNT_LO: on byte_valid, store count[7:0].
    - count==0 → F_DONE (busy=0, done=1).
    - count>MAX_WORDS → F_ERR (busy=0, err=1).
    - Otherwise → F_DATA with word_idx=0, byte_idx=0.
  - F_DATA: each byte shifts into an assembly register, big-endian (first byte → bits 31:24). On the 4th byte (byte_idx==3), in the following cycle:
    - mem_we=1 for exactly one cycle;
    - mem_addr={word_idx,2'b00}, zero-extended to 32 bits;
    - mem_wdata=assembled word;
    - word_idx increments and byte_idx wraps to 0.
  - After the write strobe for word_idx==count-1: busy=0 and done=1 in the same cycle as the deassertion of mem_we; go F_DONE.
  - F_DONE: a new byte_valid starts a new session exactly as in F_IDLE (done cleared, busy set).
  - F_ERR: all bytes ignored; err, busy=0 held until reset.
- Framing error: frame_err in any frame state except F_ERR → F_ERR, busy=0, err=1, no further writes.
- mem_addr and mem_wdata hold their last values between strobes.
- mem_we is never asserted outside F_DATA.
- Byte throughput is at most one per 10*CLK_DIV cycles, so a write never collides with the next byte_valid.
- No inter-byte timeout: a stalled host leaves busy=1 until more bytes arrive or reset.

Test Plan:
- Run the bench with CLK_DIV=16. Send 00 02 | 20 08 00 05 | 00 00 00 0C.
  - Expect mem_we pulses with (addr 0x0, data 0x20080005), then (0x4, 0x0000000C).
  - busy is high from the first stop bit until the second strobe; then done=1.
- Send header 00 00 → no mem_we; busy pulses high between header bytes then 0; done=1; err=0.
- Send header 04 01 (1025 > MAX_WORDS) → err=1, busy=0. Following bytes produce no mem_we.
- Mid-word stop bit forced low on the 2nd data byte → err=1, busy=0, no strobe for that word.
  - Further traffic is ignored until rst=0 for one cycle, after which all outputs are 0.
- Glitch: rxd low for 4 cycles (< CLK_DIV/2) in IDLE → no byte_valid, no state change.
  - A following valid session loads correctly.
- Session 1 (1 word 0xDEADBEEF) completes with done=1. Session 2 (1 word 0x12345678) starts:
  - done drops on the first header byte;
  - word lands at addr 0x0;
  - done=1 again.
- Assert rst=0 during the 3rd data byte → all outputs 0 next cycle. A fresh session then loads from addr 0.
